// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: takes a pattern word over valid/ready and shifts it out
// MSB-first on a single registered line, with optional repeats and idle gaps between them.
module seq_pattern_tx #(
  parameter int unsigned PATTERN_W  = 3,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned GAP_W      = 4,
  parameter logic        IDLE_LEVEL = 1'b0,
  parameter int unsigned LEN_W      = $clog2(PATTERN_W + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PATTERN_W-1:0] in_pattern,
  input  logic [LEN_W-1:0]     in_len,
  input  logic [CNT_W-1:0]     in_repeat,
  input  logic [GAP_W-1:0]     in_gap,
  output logic                 out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(PATTERN_W);

  logic [1:0]           state_q, state_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [LEN_W-1:0]     bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]     rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] first_idx;
  logic             reload;
  logic             finish;

  assign len_eff   = ((in_len == '0) || (in_len > MaxLen)) ? MaxLen : in_len;
  assign first_idx = len_eff - LEN_W'(1);
  assign in_ready  = (state_q == StIdle) && !rst;

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    gap_d       = gap_q;
    bit_idx_d   = bit_idx_q;
    rep_cnt_d   = rep_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    out_d       = IDLE_LEVEL;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    reload      = 1'b0;
    finish      = 1'b0;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Shadow the request so input changes cannot disturb the frame in flight.
          pat_d       = in_pattern;
          len_d       = len_eff;
          gap_d       = in_gap;
          rep_cnt_d   = in_repeat;
          state_d     = StShift;
          bit_idx_d   = first_idx;
          out_d       = in_pattern[first_idx];
          out_valid_d = 1'b1;
        end
      end
      StShift: begin
        if (bit_idx_q != '0) begin
          bit_idx_d   = bit_idx_q - LEN_W'(1);
          out_d       = pat_q[bit_idx_d];
          out_valid_d = 1'b1;
        end else if (gap_q != '0) begin
          state_d   = StGap;
          gap_cnt_d = gap_q;
        end else if (rep_cnt_q != '0) begin
          reload = 1'b1;
        end else begin
          finish = 1'b1;
        end
      end
      StGap: begin
        // gap_cnt holds the idle cycles remaining, including the current one.
        if (gap_cnt_q > GAP_W'(1)) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end else begin
          gap_cnt_d = '0;
          if (rep_cnt_q != '0) reload = 1'b1;
          else                 finish = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (reload) begin
      state_d     = StShift;
      rep_cnt_d   = rep_cnt_q - CNT_W'(1);
      bit_idx_d   = len_q - LEN_W'(1);
      out_d       = pat_q[bit_idx_d];
      out_valid_d = 1'b1;
    end
    if (finish) begin
      state_d = StIdle;
      done_d  = 1'b1;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pat_q       <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      bit_idx_q   <= '0;
      rep_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      out_q       <= IDLE_LEVEL;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      bit_idx_q   <= bit_idx_d;
      rep_cnt_q   <= rep_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed frames plus random traffic, checked every cycle against
// a queue-based model that expands each accepted request into its per-cycle line contents.
module tb_seq_pattern_tx;

  localparam bit IdleLvl = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_pattern = '0;
  logic [1:0] in_len = '0;
  logic [3:0] in_repeat = '0;
  logic [3:0] in_gap = '0;
  logic       in_ready, out, out_valid, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: upcoming line cycles of the frame in flight, plus what is on the line now.
  bit q_o[$];
  bit q_v[$];
  bit m_busy  = 1'b0;
  bit m_out   = IdleLvl;
  bit m_valid = 1'b0;
  bit m_done  = 1'b0;

  seq_pattern_tx #(
    .PATTERN_W (3),
    .CNT_W     (4),
    .GAP_W     (4),
    .IDLE_LEVEL(IdleLvl)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pattern(in_pattern),
    .in_len    (in_len),
    .in_repeat (in_repeat),
    .in_gap    (in_gap),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic build_frame(input bit [2:0] p, input bit [1:0] l, input bit [3:0] r,
                             input bit [3:0] g);
    int len;
    len = (l == 0) ? 3 : int'(l);
    for (int rep = 0; rep <= int'(r); rep++) begin
      for (int i = len - 1; i >= 0; i--) begin
        q_o.push_back(p[i]);
        q_v.push_back(1'b1);
      end
      for (int k = 0; k < int'(g); k++) begin
        q_o.push_back(IdleLvl);
        q_v.push_back(1'b0);
      end
    end
  endtask

  task automatic step(input bit v, input bit [2:0] p, input bit [1:0] l, input bit [3:0] r,
                      input bit [3:0] g, input bit rs);
    @(negedge clk);
    rst        = rs;
    in_valid   = v;
    in_pattern = p;
    in_len     = l;
    in_repeat  = r;
    in_gap     = g;
    #1;
    check_eq("in_ready", in_ready, !m_busy && !rs);
    @(posedge clk);
    if (rs) begin
      q_o.delete();
      q_v.delete();
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_out   = IdleLvl;
      m_valid = 1'b0;
    end else if (m_busy) begin
      m_done = 1'b0;
      if (q_o.size() > 0) begin
        m_out   = q_o.pop_front();
        m_valid = q_v.pop_front();
      end else begin
        m_busy  = 1'b0;
        m_done  = 1'b1;
        m_out   = IdleLvl;
        m_valid = 1'b0;
      end
    end else begin
      m_done  = 1'b0;
      m_out   = IdleLvl;
      m_valid = 1'b0;
      if (v) begin
        build_frame(p, l, r, g);
        m_out   = q_o.pop_front();
        m_valid = q_v.pop_front();
        m_busy  = 1'b1;
      end
    end
    #1;
    check_eq("out", out, m_out);
    check_eq("out_valid", out_valid, m_valid);
    check_eq("busy", busy, m_busy);
    check_eq("done", done, m_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 2'd0, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    repeat (3) step(1'b0, 3'b000, 2'd0, 4'd0, 4'd0, 1'b1);
    idle(2);
    // Single 110 frame, then repeated frame with gaps.
    step(1'b1, 3'b110, 2'd3, 4'd0, 4'd0, 1'b0);
    idle(5);
    step(1'b1, 3'b110, 2'd3, 4'd2, 4'd2, 1'b0);
    idle(18);
    // Short length and zero length (clamps to full width).
    step(1'b1, 3'b110, 2'd2, 4'd0, 4'd0, 1'b0);
    idle(4);
    step(1'b1, 3'b110, 2'd0, 4'd0, 4'd0, 1'b0);
    idle(5);
    // in_valid held high: second request taken on the done cycle.
    step(1'b1, 3'b110, 2'd3, 4'd0, 4'd0, 1'b0);
    repeat (4) step(1'b1, 3'b011, 2'd3, 4'd0, 4'd0, 1'b0);
    idle(6);
    // Reset mid-frame, with in_valid asserted during reset.
    step(1'b1, 3'b110, 2'd3, 4'd3, 4'd0, 1'b0);
    step(1'b1, 3'b101, 2'd3, 4'd0, 4'd0, 1'b1);
    step(1'b1, 3'b101, 2'd3, 4'd0, 4'd0, 1'b1);
    idle(3);
    // Inputs changing mid-frame must not disturb it.
    step(1'b1, 3'b101, 2'd3, 4'd1, 4'd1, 1'b0);
    step(1'b1, 3'b010, 2'd1, 4'd5, 4'd3, 1'b0);
    step(1'b0, 3'b111, 2'd2, 4'd0, 4'd0, 1'b0);
    step(1'b1, 3'b000, 2'd0, 4'd0, 4'd0, 1'b0);
    idle(8);
    for (int i = 0; i < 3000; i++) begin
      step(1'(($urandom_range(0, 1))),
           3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)),
           ($urandom_range(0, 79) == 0));
    end
    idle(30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
